// File: rtl/tdm_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_slot_scheduler
//  Description : Weighted round-robin scheduler that time-shares one output
//                datapath slot between NUM_INPUTS valid/ready lanes. Each
//                lane owns the slot for up to its burst quota of beats, and
//                every beat is tagged with its source lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_scheduler #(
   parameter int NUM_INPUTS   = 2,
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 4,
   parameter int SRC_WIDTH    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_INPUTS-1:0]              req_valid,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_INPUTS-1:0]              req_ready,
   input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weight,
   output logic                               out_valid,
   output logic [DATA_WIDTH-1:0]              out_data,
   output logic [SRC_WIDTH-1:0]               out_src,
   output logic                               out_last,
   input  logic                               out_ready
);

   // Reset owner is the last lane so the first search begins at lane 0.
   localparam logic [SRC_WIDTH-1:0]    C_LAST_LANE = SRC_WIDTH'(NUM_INPUTS - 1);
   localparam logic [WEIGHT_WIDTH-1:0] C_ONE       = WEIGHT_WIDTH'(1);
   localparam logic [WEIGHT_WIDTH-1:0] C_ZERO      = '0;

   // Slot ownership state
   logic [SRC_WIDTH-1:0]    r_cur;
   logic [WEIGHT_WIDTH-1:0] r_rem;

   // Output beat register
   logic                    r_out_valid;
   logic [DATA_WIDTH-1:0]   r_out_data;
   logic [SRC_WIDTH-1:0]    r_out_src;
   logic                    r_out_last;

   // Arbitration signals
   logic                    w_load;
   logic                    w_keep;
   logic                    w_any;
   logic                    w_xfer;
   logic [SRC_WIDTH-1:0]    w_sel;
   logic                    w_found;
   logic [WEIGHT_WIDTH-1:0] w_sel_weight;
   logic [WEIGHT_WIDTH-1:0] w_quota;
   logic [DATA_WIDTH-1:0]   w_sel_data;

   // The output register can take a new beat when empty or being drained.
   assign w_load = !r_out_valid || out_ready;

   // The current owner keeps the slot while it has quota left and is asking.
   assign w_keep = (r_rem != C_ZERO) && req_valid[r_cur];
   assign w_any  = w_keep || (|req_valid);

   // Lane select: owner if it keeps the slot, else first valid lane after cur (cur checked last).
   always_comb begin
      w_sel   = r_cur;
      w_found = 1'b0;
      if (w_keep) begin
         w_found = 1'b1;
      end else begin
         for (int k = 1; k <= NUM_INPUTS; k++) begin
            if (!w_found && req_valid[(int'(r_cur) + k) % NUM_INPUTS]) begin
               w_sel   = SRC_WIDTH'((int'(r_cur) + k) % NUM_INPUTS);
               w_found = 1'b1;
            end
         end
      end
   end

   // One-hot-or-zero accept, suppressed while reset is asserted.
   generate
      for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ready
         assign req_ready[i] = !rst && w_load && w_any && (w_sel == SRC_WIDTH'(i));
      end
   endgenerate

   assign w_xfer = |(req_valid & req_ready);

   // Quota of a new slot; a zero weight still grants one beat.
   assign w_sel_weight = weight[w_sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];
   assign w_quota      = (w_sel_weight == C_ZERO) ? C_ONE : w_sel_weight;
   assign w_sel_data   = req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];

   // Slot owner and remaining-beat counter: decrement on continue, reload on new slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur <= C_LAST_LANE;
         r_rem <= C_ZERO;
      end else if (w_xfer) begin
         if (w_keep) begin
            r_rem <= r_rem - C_ONE;
         end else begin
            r_cur <= w_sel;
            r_rem <= w_quota - C_ONE;
         end
      end
   end

   // Output beat register: capture on transfer, empty on idle load, hold under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_out_last  <= 1'b0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_out_src   <= w_sel;
         r_out_last  <= w_keep ? (r_rem == C_ONE) : (w_quota == C_ONE);
      end else if (w_load) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_tdm_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_slot_scheduler
//  Description : Self-checking bench for tdm_slot_scheduler: directed
//                scenarios plus randomized traffic against a lane-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_slot_scheduler;

   localparam int N  = 2;
   localparam int DW = 8;
   localparam int WW = 4;
   localparam int SW = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic [N*WW-1:0] weight;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;
   logic            out_last;
   logic            out_ready;

   int n_tests = 0;
   int n_fail  = 0;
   bit inc_en  = 1'b0;

   // Reference model: owning lane, beats left in its slot, and the visible beat
   int            m_cur;
   int            m_rem;
   bit            m_ov;
   logic [DW-1:0] m_od;
   int            m_os;
   bit            m_ol;

   tdm_slot_scheduler #(
      .NUM_INPUTS  (N),
      .DATA_WIDTH  (DW),
      .WEIGHT_WIDTH(WW),
      .SRC_WIDTH   (SW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_ready(req_ready),
      .weight   (weight),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_src  (out_src),
      .out_last (out_last),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Lane that would be granted now: the owner if it still has quota and asks,
   // otherwise the next asking lane after the owner in circular order.
   function automatic int m_pick();
      if (m_rem != 0 && req_valid[m_cur]) return m_cur;
      for (int k = 1; k <= N; k++) begin
         int l;
         l = (m_cur + k) % N;
         if (req_valid[l]) return l;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] m_ready();
      logic [N-1:0] r;
      int p;
      r = '0;
      p = m_pick();
      if (!rst && (!m_ov || out_ready) && p >= 0) r[p] = 1'b1;
      return r;
   endfunction

   // Advance one clock: apply the model at the edge, then return at the falling edge.
   task automatic tick();
      logic [N-1:0] acc;
      int p;
      int w;
      #1;
      acc = req_valid & req_ready;
      @(posedge clk);
      if (rst) begin
         m_cur = N - 1; m_rem = 0; m_ov = 0; m_od = '0; m_os = 0; m_ol = 0;
      end else if (!m_ov || out_ready) begin
         p = m_pick();
         if (p < 0) begin
            m_ov = 0;
         end else begin
            if (p == m_cur && m_rem != 0) begin
               m_rem = m_rem - 1;
               m_ol  = (m_rem == 0);
            end else begin
               w = int'(weight[p*WW +: WW]);
               if (w == 0) w = 1;
               m_cur = p;
               m_rem = w - 1;
               m_ol  = (w == 1);
            end
            m_ov = 1;
            m_od = req_data[p*DW +: DW];
            m_os = p;
         end
      end
      @(negedge clk);
      if (inc_en) begin
         for (int i = 0; i < N; i++)
            if (acc[i]) req_data[i*DW +: DW] = req_data[i*DW +: DW] + 8'd1;
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req_valid = '0; out_ready = 1'b1; rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1; n_tests++;
         if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
         tick(); n_tests++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1; n_tests++;
         if (req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_ready: got %b want 00", req_ready); end
         tick(); n_tests++;
         if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_out: got v=%b d=%h s=%0d l=%b want 0/00/0/0", out_valid, out_data, out_src, out_last);
         end
      end
   endtask

   task automatic test_alternating();
      weight = 8'h11; req_data = 16'h2211; req_valid = 2'b11; out_ready = 1'b1;
      do_reset(1);
      #1; n_tests++;
      if (req_ready !== 2'b01) begin n_fail++; $display("FAIL alt_first_ready: got %b want 01", req_ready); end
      for (int i = 0; i < 6; i++) begin
         tick(); n_tests++;
         if (out_valid !== 1'b1 || out_src !== SW'(i % 2) || out_data !== ((i % 2) ? 8'h22 : 8'h11) || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL alt_beat%0d: got v=%b s=%0d d=%h l=%b want 1/%0d/%h/1",
                     i, out_valid, out_src, out_data, out_last, i % 2, (i % 2) ? 8'h22 : 8'h11);
         end
      end
   endtask

   task automatic test_weighted();
      int p;
      int es;
      bit el;
      weight = 8'h32; req_data = 16'hB1A0; req_valid = 2'b11; out_ready = 1'b1;
      do_reset(1);
      for (int i = 0; i < 10; i++) begin
         p = i % 5; es = (p < 2) ? 0 : 1; el = (p == 1 || p == 4);
         tick(); n_tests++;
         if (out_valid !== 1'b1 || out_src !== SW'(es) || out_last !== el || out_data !== (es ? 8'hB1 : 8'hA0)) begin
            n_fail++;
            $display("FAIL wt_beat%0d: got v=%b s=%0d l=%b d=%h want 1/%0d/%b", i, out_valid, out_src, out_last, out_data, es, el);
         end
      end
      weight = 8'h30;
      do_reset(1);
      for (int i = 0; i < 8; i++) begin
         p = i % 4; es = (p == 0) ? 0 : 1; el = (p == 0 || p == 3);
         tick(); n_tests++;
         if (out_valid !== 1'b1 || out_src !== SW'(es) || out_last !== el) begin
            n_fail++;
            $display("FAIL wt0_beat%0d: got v=%b s=%0d l=%b want 1/%0d/%b", i, out_valid, out_src, out_last, es, el);
         end
      end
   endtask

   task automatic test_backpressure();
      int            es [5] = '{0, 1, 1, 1, 0};
      logic [DW-1:0] ed [5] = '{8'h01, 8'h80, 8'h81, 8'h82, 8'h02};
      bit            el [5] = '{1, 0, 0, 1, 0};
      weight = 8'h32; req_data = 16'h8000; req_valid = 2'b11; out_ready = 1'b1; inc_en = 1'b1;
      do_reset(1);
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1; n_tests++;
         if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 00", c, req_ready); end
         tick(); n_tests++;
         if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got v=%b s=%0d d=%h l=%b want 1/0/00/0", c, out_valid, out_src, out_data, out_last);
         end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(); n_tests++;
         if (out_valid !== 1'b1 || out_src !== SW'(es[i]) || out_data !== ed[i] || out_last !== el[i]) begin
            n_fail++;
            $display("FAIL bp_resume%0d: got v=%b s=%0d d=%h l=%b want 1/%0d/%h/%b",
                     i, out_valid, out_src, out_data, out_last, es[i], ed[i], el[i]);
         end
      end
      inc_en = 1'b0;
   endtask

   task automatic test_forfeit();
      weight = 8'h44; req_data = 16'h2211; req_valid = 2'b11; out_ready = 1'b1;
      do_reset(1);
      for (int i = 0; i < 2; i++) begin
         tick(); n_tests++;
         if (out_valid !== 1'b1 || out_src !== 1'b0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL ff_lane0_%0d: got v=%b s=%0d l=%b want 1/0/0", i, out_valid, out_src, out_last);
         end
      end
      req_valid = 2'b10;
      #1; n_tests++;
      if (req_ready !== 2'b10) begin n_fail++; $display("FAIL ff_switch_ready: got %b want 10", req_ready); end
      for (int k = 0; k < 5; k++) begin
         tick(); n_tests++;
         if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== 8'h22 || out_last !== (k == 3)) begin
            n_fail++;
            $display("FAIL ff_lane1_%0d: got v=%b s=%0d d=%h l=%b want 1/1/22/%b", k, out_valid, out_src, out_data, out_last, k == 3);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int es [3] = '{0, 0, 1};
      bit el [3] = '{0, 1, 0};
      weight = 8'h32; req_data = 16'hB1A0; req_valid = 2'b11; out_ready = 1'b1;
      do_reset(1);
      repeat (4) tick();
      n_tests++;
      if (out_src !== 1'b1 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL rm_pre: got v=%b s=%0d want 1/1", out_valid, out_src);
      end
      rst = 1'b1;
      #1; n_tests++;
      if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rm_ready: got %b want 00", req_ready); end
      tick(); n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_drop: got %b want 0", out_valid); end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); n_tests++;
         if (out_valid !== 1'b1 || out_src !== SW'(es[i]) || out_last !== el[i]) begin
            n_fail++;
            $display("FAIL rm_restart%0d: got v=%b s=%0d l=%b want 1/%0d/%b", i, out_valid, out_src, out_last, es[i], el[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0] er;
      for (int c = 0; c < 600; c++) begin
         req_valid = N'($urandom);
         req_data  = (N*DW)'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         rst       = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 19) == 0) weight = (N*WW)'($urandom);
         #1;
         er = m_ready();
         n_tests++;
         if (req_ready !== er) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, er); end
         tick(); n_tests++;
         if (out_valid !== m_ov) begin
            n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, m_ov);
         end else if (m_ov && (out_data !== m_od || out_src !== SW'(m_os) || out_last !== m_ol)) begin
            n_fail++;
            $display("FAIL rnd_beat c%0d: got d=%h s=%0d l=%b want %h/%0d/%b", c, out_data, out_src, out_last, m_od, m_os, m_ol);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      m_cur = N - 1; m_rem = 0; m_ov = 0; m_od = '0; m_os = 0; m_ol = 0;
      rst = 1'b1; req_valid = '0; req_data = '0; weight = '0; out_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_alternating();
      test_weighted();
      test_backpressure();
      test_forfeit();
      test_reset_mid_burst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
